// File: rtl/quiz_host_ctrl_if.sv
// Signal bundle between the quiz host controller and its surroundings (buttons, Responder, display).
// master: host/Responder side driving the controls; slave: the controller itself.
interface quiz_host_ctrl_if #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned SCORE_W = 4
);
  logic                 start;
  logic                 tick;
  logic                 stoptimer;
  logic [3:0]           result;
  logic                 award;
  logic                 deny;
  logic                 showready;
  logic [CNT_W-1:0]     remaining;
  logic [1:0]           round_state;
  logic [3:0]           winner;
  logic                 winner_valid;
  logic                 timeout;
  logic                 foul;
  logic [4*SCORE_W-1:0] scores;

  modport master (
    output start, tick, stoptimer, result, award, deny,
    input  showready, remaining, round_state, winner, winner_valid, timeout, foul, scores
  );

  modport slave (
    input  start, tick, stoptimer, result, award, deny,
    output showready, remaining, round_state, winner, winner_valid, timeout, foul, scores
  );
endinterface

// File: rtl/quiz_host_ctrl.sv
// Quizmaster round controller: opens rounds, runs the answer countdown, judges and keeps scores.
// Optional early-press penalty is enabled by defining FOUL_DETECT_EN.
module quiz_host_ctrl #(
  parameter int unsigned ANSWER_TIME = 10,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SCORE_W     = 4
) (
  input logic             clk,
  input logic             rst,
  quiz_host_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StOpen    = 2'd1,
    StJudge   = 2'd2,
    StTimeout = 2'd3
  } state_e;

  state_e                     state_q;
  logic                       showready_q;
  logic [CNT_W-1:0]           remaining_q;
  logic [3:0]                 winner_q;
  logic                       winner_valid_q;
  logic                       timeout_q;
  logic [3:0][SCORE_W-1:0]    scores_q;
  logic                       result_onehot;

  assign result_onehot = $onehot(bus.result);

`ifdef FOUL_DETECT_EN
  logic foul_q;
  assign bus.foul = foul_q;
`else
  assign bus.foul = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      showready_q    <= 1'b0;
      remaining_q    <= '0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      scores_q       <= '0;
`ifdef FOUL_DETECT_EN
      foul_q         <= 1'b0;
`endif
    end else begin
`ifdef FOUL_DETECT_EN
      foul_q <= 1'b0;
`endif
      unique case (state_q)
        StIdle, StTimeout: begin
          if (bus.start) begin
            state_q     <= StOpen;
            showready_q <= 1'b1;
            timeout_q   <= 1'b0;
            remaining_q <= CNT_W'(ANSWER_TIME);
            winner_q    <= '0;
          end
`ifdef FOUL_DETECT_EN
          // Early press while idle costs the presser a point; start takes precedence.
          else if (state_q == StIdle && bus.stoptimer && result_onehot) begin
            foul_q <= 1'b1;
            for (int n = 0; n < 4; n++) begin
              if (bus.result[n] && scores_q[n] != '0) begin
                scores_q[n] <= scores_q[n] - SCORE_W'(1);
              end
            end
          end
`endif
        end
        StOpen: begin
          // A valid buzz beats a tick in the same cycle and freezes the countdown.
          if (bus.stoptimer && result_onehot) begin
            state_q        <= StJudge;
            showready_q    <= 1'b0;
            winner_valid_q <= 1'b1;
            winner_q       <= bus.result;
          end else if (bus.tick) begin
            if (remaining_q > CNT_W'(1)) begin
              remaining_q <= remaining_q - CNT_W'(1);
            end else begin
              remaining_q <= '0;
              state_q     <= StTimeout;
              showready_q <= 1'b0;
              timeout_q   <= 1'b1;
            end
          end
        end
        StJudge: begin
          if (bus.deny) begin
            state_q        <= StIdle;
            winner_valid_q <= 1'b0;
          end else if (bus.award) begin
            state_q        <= StIdle;
            winner_valid_q <= 1'b0;
            for (int n = 0; n < 4; n++) begin
              if (winner_q[n] && scores_q[n] != '1) begin
                scores_q[n] <= scores_q[n] + SCORE_W'(1);
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.showready    = showready_q;
  assign bus.remaining    = remaining_q;
  assign bus.round_state  = state_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = winner_valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.scores       = scores_q;

endmodule
